// File: rtl/gmsk_pkg.sv
// Shared GMSK constants so modulator and demodulator agree on sample width,
// oversampling and the meaning of a bit.
package gmsk_pkg;

   localparam int GMSK_SAMPLE_BITS = 8;
   localparam int GMSK_SPS         = 8;

   // Counter-clockwise rotation over a symbol is a 1 on both ends of the link.
   localparam logic GMSK_BIT_CCW = 1'b1;

   function automatic logic decide_bit(input logic metric_positive);
      return metric_positive ? GMSK_BIT_CCW : ~GMSK_BIT_CCW;
   endfunction

endpackage

// File: rtl/gmsk_xprod.sv
// Registered imaginary part of conj(prev)*cur: p_a = prev_i*cur_q, p_b = prev_q*cur_i,
// difference presented combinationally to the integrator one clock later.
module gmsk_xprod
   import gmsk_pkg::*;
#(
   parameter int SAMPLE_BITS = GMSK_SAMPLE_BITS,
   localparam int PROD_BITS  = 2 * SAMPLE_BITS,
   localparam int XPROD_BITS = PROD_BITS + 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          sample_valid,
   input  logic                          prev_valid,
   input  logic signed [SAMPLE_BITS-1:0] cur_i,
   input  logic signed [SAMPLE_BITS-1:0] cur_q,
   input  logic signed [SAMPLE_BITS-1:0] prev_i,
   input  logic signed [SAMPLE_BITS-1:0] prev_q,
   output logic signed [XPROD_BITS-1:0]  xprod,
   output logic                          xprod_valid
);

   logic signed [PROD_BITS-1:0] p_a;
   logic signed [PROD_BITS-1:0] p_b;

   always_ff @(posedge clock) begin
      if (reset) begin
         p_a         <= '0;
         p_b         <= '0;
         xprod_valid <= 1'b0;
      end else begin
         xprod_valid <= sample_valid & ~flush;
         if (sample_valid) begin
            // Without a previous sample there is no rotation to measure.
            if (prev_valid) begin
               p_a <= PROD_BITS'(prev_i) * PROD_BITS'(cur_q);
               p_b <= PROD_BITS'(prev_q) * PROD_BITS'(cur_i);
            end else begin
               p_a <= '0;
               p_b <= '0;
            end
         end
      end
   end

   assign xprod = XPROD_BITS'(p_a) - XPROD_BITS'(p_b);

endmodule

// File: rtl/gmsk_rx_diff.sv
// Non-coherent differential GMSK demodulator: integrates the per-sample phase-rotation
// sign over one symbol and dumps a hard bit plus signed soft metric.
module gmsk_rx_diff
   import gmsk_pkg::*;
#(
   parameter int SAMPLE_BITS = GMSK_SAMPLE_BITS,
   parameter int SPS         = GMSK_SPS,
   localparam int CNT_BITS   = $clog2(SPS),
   localparam int ACC_BITS   = 2 * SAMPLE_BITS + 1 + CNT_BITS
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          sample_strobe,
   input  logic signed [SAMPLE_BITS-1:0] inphase_in,
   input  logic signed [SAMPLE_BITS-1:0] quadrature_in,
   input  logic                          phase_load,
   input  logic [CNT_BITS-1:0]           symbol_phase,
   output logic                          bit_out,
   output logic                          bit_valid,
   output logic signed [ACC_BITS-1:0]    soft_out
);

   localparam int XPROD_BITS = 2 * SAMPLE_BITS + 1;

   logic signed [SAMPLE_BITS-1:0] cur_i;
   logic signed [SAMPLE_BITS-1:0] cur_q;
   logic signed [SAMPLE_BITS-1:0] prev_i;
   logic signed [SAMPLE_BITS-1:0] prev_q;
   logic                          prev_valid;
   logic                          stage0_valid;
   logic                          stage0_prev_valid;

   logic signed [XPROD_BITS-1:0]  xprod;
   logic                          xprod_valid;

   logic signed [ACC_BITS-1:0]    acc;
   logic signed [ACC_BITS-1:0]    sum;
   logic [CNT_BITS-1:0]           cnt;
   logic [CNT_BITS-1:0]           load_value;
   logic                          last_sample;
   logic                          metric_positive;

   always_ff @(posedge clock) begin
      if (reset) begin
         cur_i             <= '0;
         cur_q             <= '0;
         prev_i            <= '0;
         prev_q            <= '0;
         prev_valid        <= 1'b0;
         stage0_valid      <= 1'b0;
         stage0_prev_valid <= 1'b0;
      end else begin
         stage0_valid <= sample_strobe;
         if (sample_strobe) begin
            cur_i             <= inphase_in;
            cur_q             <= quadrature_in;
            prev_i            <= cur_i;
            prev_q            <= cur_q;
            prev_valid        <= 1'b1;
            stage0_prev_valid <= prev_valid;
         end
      end
   end

   // A load discards the sample waiting in stage 0; the one in stage 1 is
   // ignored below because the load branch takes priority.
   gmsk_xprod #(
      .SAMPLE_BITS (SAMPLE_BITS)
   ) u_xprod (
      .clock        (clock),
      .reset        (reset),
      .flush        (phase_load),
      .sample_valid (stage0_valid),
      .prev_valid   (stage0_prev_valid),
      .cur_i        (cur_i),
      .cur_q        (cur_q),
      .prev_i       (prev_i),
      .prev_q       (prev_q),
      .xprod        (xprod),
      .xprod_valid  (xprod_valid)
   );

   assign sum             = acc + ACC_BITS'(xprod);
   assign last_sample     = (cnt == CNT_BITS'(SPS - 1));
   assign metric_positive = ~sum[ACC_BITS-1] && (sum != '0);
   // Out-of-range phases clamp to zero rather than wrapping.
   assign load_value      = (int'(symbol_phase) >= SPS) ? '0 : symbol_phase;

   always_ff @(posedge clock) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         soft_out  <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
      end else begin
         bit_valid <= 1'b0;
         if (phase_load) begin
            cnt <= load_value;
            acc <= '0;
         end else if (xprod_valid) begin
            if (last_sample) begin
               soft_out  <= sum;
               bit_out   <= decide_bit(metric_positive);
               bit_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + CNT_BITS'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_gmsk_rx_diff.sv
// Directed bench for gmsk_rx_diff: sample-level model feeds an expected queue of
// {bit, soft} per symbol; timing corners are checked directly.
module tb_gmsk_rx_diff;

   localparam int SB   = 8;
   localparam int SPS  = 8;
   localparam int CB   = 3;
   localparam int AB   = 2 * SB + 1 + CB;
   localparam int SPSC = 6;
   localparam real STEP = 11.25;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 sample_strobe;
   logic signed [SB-1:0] inphase_in;
   logic signed [SB-1:0] quadrature_in;
   logic                 phase_load;
   logic [CB-1:0]        symbol_phase;
   logic                 bit_out;
   logic                 bit_valid;
   logic signed [AB-1:0] soft_out;

   logic                 phase_load_c;
   logic [CB-1:0]        symbol_phase_c;
   logic                 bit_out_c;
   logic                 bit_valid_c;
   logic signed [AB-1:0] soft_out_c;

   int checks = 0;
   int errors = 0;

   logic [AB:0] exp_q[$];
   int          m_cnt;
   int          m_acc;
   int          m_pi;
   int          m_pq;
   bit          m_pv;
   real         ph;

   always #5 clock = ~clock;

   gmsk_rx_diff #(.SAMPLE_BITS(SB), .SPS(SPS)) dut (
      .clock         (clock),
      .reset         (reset),
      .sample_strobe (sample_strobe),
      .inphase_in    (inphase_in),
      .quadrature_in (quadrature_in),
      .phase_load    (phase_load),
      .symbol_phase  (symbol_phase),
      .bit_out       (bit_out),
      .bit_valid     (bit_valid),
      .soft_out      (soft_out)
   );

   gmsk_rx_diff #(.SAMPLE_BITS(SB), .SPS(SPSC)) dut_c (
      .clock         (clock),
      .reset         (reset),
      .sample_strobe (sample_strobe),
      .inphase_in    (inphase_in),
      .quadrature_in (quadrature_in),
      .phase_load    (phase_load_c),
      .symbol_phase  (symbol_phase_c),
      .bit_out       (bit_out_c),
      .bit_valid     (bit_valid_c),
      .soft_out      (soft_out_c)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample-level reference: rotation metric prev_i*cur_q - prev_q*cur_i per sample.
   task automatic model_sample(input int i, input int q);
      int x;
      x = m_pv ? (m_pi * q - m_pq * i) : 0;
      m_acc += x;
      m_pi = i;
      m_pq = q;
      m_pv = 1'b1;
      if (m_cnt == SPS - 1) begin
         exp_q.push_back({(m_acc > 0) ? 1'b1 : 1'b0, AB'(m_acc)});
         m_acc = 0;
         m_cnt = 0;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_acc = 0;
      m_pi  = 0;
      m_pq  = 0;
      m_pv  = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_load(input int p);
      m_cnt = p;
      m_acc = 0;
   endtask

   task automatic send(input int i, input int q);
      sample_strobe = 1'b1;
      inphase_in    = SB'(i);
      quadrature_in = SB'(q);
      model_sample(i, q);
      @(negedge clock);
      sample_strobe = 1'b0;
   endtask

   task automatic send_rot(input real step);
      ph += step;
      send(int'(100.0 * $cos(ph * 3.14159265358979 / 180.0)),
           int'(100.0 * $sin(ph * 3.14159265358979 / 180.0)));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic load_main(input int p);
      phase_load   = 1'b1;
      symbol_phase = CB'(p);
      @(negedge clock);
      phase_load   = 1'b0;
      model_load(p);
   endtask

   always @(negedge clock) begin
      if (!reset && bit_valid) begin
         logic [AB:0] e;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL spurious_bit_valid observed=1 expected=0");
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("symbol_bit_soft", {bit_out, soft_out}, e);
         end
      end
   end

   initial begin
      logic [8:0] prbs;
      reset          = 1'b1;
      sample_strobe  = 1'b0;
      inphase_in     = '0;
      quadrature_in  = '0;
      phase_load     = 1'b0;
      symbol_phase   = '0;
      phase_load_c   = 1'b0;
      symbol_phase_c = '0;
      model_reset();
      ph = 0.0;
      idle(3);
      chk("reset_bit_valid", bit_valid, 0);
      chk("reset_bit_out", bit_out, 0);
      chk("reset_soft_out", soft_out, 0);
      reset = 1'b0;
      idle(1);

      // T1: +90 deg over one symbol, first sample contributes nothing
      send(100, 0);
      for (int k = 0; k < 7; k++) send_rot(STEP);
      idle(1);
      chk("t1_latency_early", bit_valid, 0);
      idle(1);
      chk("t1_bit_valid", bit_valid, 1);
      chk("t1_bit_one", bit_out, 1);
      chk("t1_soft_pos", (soft_out > 0), 1);

      // T2: -90 deg symbol, then alternating symbols with random gaps
      for (int k = 0; k < 8; k++) send_rot(-STEP);
      idle(2);
      chk("t2_bit_zero", bit_out, 0);
      chk("t2_soft_neg", (soft_out < 0), 1);
      for (int s = 0; s < 4; s++) begin
         for (int k = 0; k < 8; k++) begin
            send_rot((s % 2 == 0) ? STEP : -STEP);
            idle($urandom_range(0, 3));
         end
      end
      idle(4);

      // T4: most-negative inputs; realign so the held symbol is clean
      load_main(7);
      send(-128, -128);
      for (int k = 0; k < 8; k++) send(-128, -128);
      idle(2);
      chk("t4_const_bit", bit_out, 0);
      chk("t4_const_soft", soft_out, 0);
      send(0, 0);
      send(-128, 0);
      send(0, -128);
      for (int k = 0; k < 5; k++) send(0, 0);
      idle(2);
      chk("t4_corner_soft", soft_out, 64'(16384));
      chk("t4_corner_bit", bit_out, 1);
      idle(2);

      // T5: load mid-symbol, then load coincident with a dump
      for (int k = 0; k < 3; k++) send_rot(STEP);
      idle(3);
      load_main(5);
      for (int k = 0; k < 3; k++) send_rot(STEP);
      idle(1);
      chk("t5_load_early", bit_valid, 0);
      idle(1);
      chk("t5_load_dump", bit_valid, 1);
      for (int k = 0; k < 8; k++) send_rot(-STEP);
      idle(1);
      phase_load   = 1'b1;
      symbol_phase = CB'(2);
      @(negedge clock);
      phase_load   = 1'b0;
      void'(exp_q.pop_back());
      model_load(2);
      chk("t5_load_wins", bit_valid, 0);
      for (int k = 0; k < 6; k++) send_rot(STEP);
      idle(2);
      chk("t5_after_coincident", bit_valid, 1);
      idle(2);

      // Out-of-range phase clamps to 0 (SPS=6 instance)
      phase_load_c   = 1'b1;
      symbol_phase_c = CB'(7);
      @(negedge clock);
      phase_load_c   = 1'b0;
      for (int k = 0; k < SPSC; k++) send_rot(STEP);
      idle(1);
      chk("clamp_early", bit_valid_c, 0);
      idle(1);
      chk("clamp_dump", bit_valid_c, 1);
      idle(8);

      // T3: PRBS9 bits as rotation direction, strobes every clock
      load_main(0);
      prbs = 9'h1ff;
      for (int b = 0; b < 511; b++) begin
         for (int k = 0; k < 8; k++) send_rot(prbs[0] ? STEP : -STEP);
         prbs = {prbs[4] ^ prbs[0], prbs[8:1]};
      end
      idle(4);

      // T6: reset right behind a symbol's last sample suppresses its dump
      for (int k = 0; k < 8; k++) send_rot(STEP);
      reset         = 1'b1;
      sample_strobe = 1'b1;
      inphase_in    = 8'sd50;
      quadrature_in = 8'sd50;
      @(negedge clock);
      reset         = 1'b0;
      sample_strobe = 1'b0;
      model_reset();
      chk("t6_bit_valid", bit_valid, 0);
      chk("t6_bit_out", bit_out, 0);
      chk("t6_soft_out", soft_out, 0);
      for (int k = 0; k < 8; k++) send_rot(STEP);
      idle(6);
      chk("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
